// File: rtl/copperv_pkg.sv
// rtl/copperv_pkg.sv - shared source ids, arbiter FSM encodings and round-robin helper
package copperv_pkg;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_GNT  = 1'b1
    } rd_state_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_GNT  = 1'b1
    } wr_state_t;

    // With both requesting, the source that did not win last time wins now.
    function automatic src_t rr_pick(input logic i_req, input logic d_req, input src_t last);
        src_t pick;
        if (i_req && d_req) begin
            if (last == SRC_I) pick = SRC_D;
            else               pick = SRC_I;
        end else if (d_req) begin
            pick = SRC_D;
        end else begin
            pick = SRC_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_src_fifo.sv
// rtl/arb_src_fifo.sv - in-order source-id FIFO that routes read responses to their requester
module arb_src_fifo #(
    parameter int depth = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);
    localparam logic [PW-1:0] LAST = PW'(depth - 1);

    logic          mem [depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(depth));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one memory port between the instruction and data buses
module bus_arbiter
    import copperv_pkg::*;
#(
    parameter int bus_width       = 32,
    parameter int max_outstanding = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_raddr_valid,
    input  logic [bus_width-1:0] i_raddr,
    output logic                 i_raddr_ready,
    output logic                 i_rdata_valid,
    output logic [bus_width-1:0] i_rdata,
    input  logic                 i_rdata_ready,
    input  logic                 i_waddr_valid,
    input  logic [bus_width-1:0] i_waddr,
    output logic                 i_waddr_ready,
    input  logic                 i_wdata_valid,
    input  logic [bus_width-1:0] i_wdata,
    output logic                 i_wdata_ready,
    input  logic                 d_raddr_valid,
    input  logic [bus_width-1:0] d_raddr,
    output logic                 d_raddr_ready,
    output logic                 d_rdata_valid,
    output logic [bus_width-1:0] d_rdata,
    input  logic                 d_rdata_ready,
    input  logic                 d_waddr_valid,
    input  logic [bus_width-1:0] d_waddr,
    output logic                 d_waddr_ready,
    input  logic                 d_wdata_valid,
    input  logic [bus_width-1:0] d_wdata,
    output logic                 d_wdata_ready,
    output logic                 m_raddr_valid,
    output logic [bus_width-1:0] m_raddr,
    input  logic                 m_raddr_ready,
    input  logic                 m_rdata_valid,
    input  logic [bus_width-1:0] m_rdata,
    output logic                 m_rdata_ready,
    output logic                 m_waddr_valid,
    output logic [bus_width-1:0] m_waddr,
    input  logic                 m_waddr_ready,
    output logic                 m_wdata_valid,
    output logic [bus_width-1:0] m_wdata,
    input  logic                 m_wdata_ready,
    output logic                 err
);

    rd_state_t rd_state, rd_next;
    src_t      rd_src, rd_last, rd_pick;
    wr_state_t wr_state, wr_next;
    src_t      wr_src, wr_last, wr_pick;
    logic      waddr_done, wdata_done;
    logic      waddr_hs, wdata_hs;
    logic      src_push, src_pop, src_head, src_full, src_empty;

    arb_src_fifo #(
        .depth(max_outstanding)
    ) u_src_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (src_push),
        .push_data(rd_src),
        .pop      (src_pop),
        .head     (src_head),
        .full     (src_full),
        .empty    (src_empty)
    );

    assign rd_pick = rr_pick(i_raddr_valid, d_raddr_valid, rd_last);
    assign wr_pick = rr_pick(i_waddr_valid || i_wdata_valid, d_waddr_valid || d_wdata_valid, wr_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            rd_src   <= SRC_D;
            rd_last  <= SRC_I;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_IDLE && rd_next == RD_GNT) begin
                rd_src  <= rd_pick;
                rd_last <= rd_pick;
            end
        end
    end

    always_comb begin
        rd_next       = rd_state;
        m_raddr_valid = 1'b0;
        m_raddr       = '0;
        i_raddr_ready = 1'b0;
        d_raddr_ready = 1'b0;
        src_push      = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if ((i_raddr_valid || d_raddr_valid) && !src_full) begin
                    rd_next = RD_GNT;
                end
            end
            RD_GNT: begin
                if (rd_src == SRC_I) begin
                    m_raddr_valid = i_raddr_valid;
                    m_raddr       = i_raddr;
                    i_raddr_ready = m_raddr_ready;
                end else begin
                    m_raddr_valid = d_raddr_valid;
                    m_raddr       = d_raddr;
                    d_raddr_ready = m_raddr_ready;
                end
                if (m_raddr_valid && m_raddr_ready) begin
                    src_push = 1'b1;
                    rd_next  = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Responses come back in issue order, so the FIFO head names the owner.
    always_comb begin
        m_rdata_ready = 1'b0;
        i_rdata_valid = 1'b0;
        d_rdata_valid = 1'b0;
        src_pop       = 1'b0;
        if (!src_empty) begin
            if (src_head == SRC_I) begin
                m_rdata_ready = i_rdata_ready;
                i_rdata_valid = m_rdata_valid;
            end else begin
                m_rdata_ready = d_rdata_ready;
                d_rdata_valid = m_rdata_valid;
            end
            src_pop = m_rdata_valid && m_rdata_ready;
        end
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (m_rdata_valid && src_empty) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_state   <= WR_IDLE;
            wr_src     <= SRC_D;
            wr_last    <= SRC_I;
            waddr_done <= 1'b0;
            wdata_done <= 1'b0;
        end else begin
            wr_state   <= wr_next;
            waddr_done <= (wr_next == WR_GNT) && (waddr_done || waddr_hs);
            wdata_done <= (wr_next == WR_GNT) && (wdata_done || wdata_hs);
            if (wr_state == WR_IDLE && wr_next == WR_GNT) begin
                wr_src  <= wr_pick;
                wr_last <= wr_pick;
            end
        end
    end

    always_comb begin
        wr_next       = wr_state;
        m_waddr_valid = 1'b0;
        m_waddr       = '0;
        m_wdata_valid = 1'b0;
        m_wdata       = '0;
        i_waddr_ready = 1'b0;
        i_wdata_ready = 1'b0;
        d_waddr_ready = 1'b0;
        d_wdata_ready = 1'b0;
        waddr_hs      = 1'b0;
        wdata_hs      = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (i_waddr_valid || i_wdata_valid || d_waddr_valid || d_wdata_valid) begin
                    wr_next = WR_GNT;
                end
            end
            WR_GNT: begin
                if (wr_src == SRC_I) begin
                    m_waddr_valid = i_waddr_valid && !waddr_done;
                    m_waddr       = i_waddr;
                    i_waddr_ready = m_waddr_ready && !waddr_done;
                    m_wdata_valid = i_wdata_valid && !wdata_done;
                    m_wdata       = i_wdata;
                    i_wdata_ready = m_wdata_ready && !wdata_done;
                end else begin
                    m_waddr_valid = d_waddr_valid && !waddr_done;
                    m_waddr       = d_waddr;
                    d_waddr_ready = m_waddr_ready && !waddr_done;
                    m_wdata_valid = d_wdata_valid && !wdata_done;
                    m_wdata       = d_wdata;
                    d_wdata_ready = m_wdata_ready && !wdata_done;
                end
                waddr_hs = m_waddr_valid && m_waddr_ready;
                wdata_hs = m_wdata_valid && m_wdata_ready;
                if ((waddr_done || waddr_hs) && (wdata_done || wdata_hs)) begin
                    wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

endmodule
